// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch unit.
//   fetch_state_e     : request FSM states (IDLE / REQ / DROP)
//   PC_INCR           : byte distance between sequential instructions
//   RESET_PC_DEFAULT  : default address of the first fetch after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request on the bus
    ST_REQ  = 2'd1,  // live request at fetch_pc outstanding
    ST_DROP = 2'd2   // stale request outstanding; its data is thrown away
  } fetch_state_e;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundles the two handshakes of the fetch unit.
//   Memory side : imem_req/imem_addr out, imem_ack/imem_rdata in
//   Decode side : instr_valid/instr/instr_pc out, instr_ready in
// modport master is the fetch unit; modport slave is the memory + decode
// environment that faces it.
interface fetch_unit_if #(
  parameter int unsigned D_WIDTH = 32
);

  logic               imem_req;
  logic [D_WIDTH-1:0] imem_addr;
  logic               imem_ack;
  logic [D_WIDTH-1:0] imem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [D_WIDTH-1:0] instr;
  logic [D_WIDTH-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- circular buffer of fetched {pc, instr} pairs.
//   clk, rst (async, active-low)
//   flush              : synchronous; empties the queue, wins over enq/deq
//   enq, enq_pc/instr  : push one entry (caller guarantees free space)
//   deq                : pop the head (ignored when empty)
//   head_valid/pc/instr: head entry, pc/instr forced to 0 when empty
//   count              : current occupancy, 0..FQ_DEPTH
module fetch_queue #(
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             enq,
  input  logic [D_WIDTH-1:0]               enq_pc,
  input  logic [D_WIDTH-1:0]               enq_instr,
  input  logic                             deq,
  output logic                             head_valid,
  output logic [D_WIDTH-1:0]               head_pc,
  output logic [D_WIDTH-1:0]               head_instr,
  output logic [$clog2(FQ_DEPTH+1)-1:0]    count
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [D_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0] instr;
  } entry_t;

  entry_t        mem [FQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_enq;
  logic          do_deq;

  assign do_enq = enq && !flush;
  assign do_deq = deq && !flush && (count_q != '0);

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and head outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= {enq_pc, enq_instr};
  end

  // Pointers are log2(FQ_DEPTH) bits wide, so +1 wraps modulo FQ_DEPTH.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_pc    = head_valid ? mem[rd_ptr].pc    : '0;
  assign head_instr = head_valid ? mem[rd_ptr].instr : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetcher with a small fetch queue.
//   clk, rst (async, active-low)
//   bus (fetch_unit_if.master):
//     imem_req/imem_addr -> memory, imem_ack/imem_rdata <- memory
//     instr_valid/instr/instr_pc -> decode, instr_ready <- decode
//   redirect, redirect_pc : taken branch/jump; flush and refetch
//   fq_count              : fetch-queue occupancy
// One request is outstanding at most. A redirect that catches a request in
// flight parks the FSM in DROP until the stale response arrives and is
// discarded, then fetching resumes at the new PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        D_WIDTH  = 32,
  parameter int unsigned        FQ_DEPTH = 4,
  parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  fetch_unit_if.master                  bus,
  input  logic                          redirect,
  input  logic [D_WIDTH-1:0]            redirect_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int unsigned        CW      = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0]      DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [D_WIDTH-1:0] PC_STEP = D_WIDTH'(PC_INCR);
  localparam logic [D_WIDTH-1:0] ALIGN_M = ~D_WIDTH'(3);

  fetch_state_e       state_q, state_d;
  logic [D_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [D_WIDTH-1:0] addr_q;
  logic               req_q;

  logic               enq, deq, flush, space;
  logic [CW-1:0]      count_next;
  logic               head_valid;
  logic [D_WIDTH-1:0] head_pc, head_instr;

  fetch_queue #(
    .D_WIDTH  (D_WIDTH),
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .enq        (enq),
    .enq_pc     (fetch_pc_q),
    .enq_instr  (bus.imem_rdata),
    .deq        (deq),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (fq_count)
  );

  // Redirect wins over everything: the queue is flushed and any response
  // arriving in the same cycle is dropped instead of enqueued.
  assign flush = redirect;
  assign enq   = (state_q == ST_REQ) && bus.imem_ack && !redirect;
  assign deq   = head_valid && bus.instr_ready;

  // Occupancy after this edge; decides whether a new request may go out.
  always_comb begin
    count_next = fq_count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_next = fq_count + CW'(1);
        2'b01:   count_next = fq_count - CW'(1);
        default: count_next = fq_count;
      endcase
    end
  end

  assign space = (count_next < DEPTH_C);

  always_comb begin
    // NOTE: defaults come first so every path assigns every output of this
    // block; a missing assignment would otherwise infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect)  fetch_pc_d = redirect_pc & ALIGN_M;
    else if (enq)  fetch_pc_d = fetch_pc_q + PC_STEP;

    unique case (state_q)
      ST_IDLE: begin
        if (space) state_d = ST_REQ;
      end
      ST_REQ: begin
        // A completed request chains straight into the next one while the
        // queue has room, giving one fetch per cycle on zero-wait memory.
        if (bus.imem_ack)  state_d = space ? ST_REQ : ST_IDLE;
        else if (redirect) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (bus.imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= (state_d != ST_IDLE);
      // The address is captured when a live request starts and then held,
      // which keeps it stable while waiting and keeps the stale address
      // on the bus throughout DROP.
      if (state_d == ST_REQ) addr_q <= fetch_pc_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit (D_WIDTH=32, FQ_DEPTH=4).
// The reference model tracks the program-level view: the next PC to fetch,
// whether the request on the bus is live or stale, and a queue of fetched
// {pc, instr} pairs waiting for decode.
module tb_fetch_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fq_count;

  fetch_unit_if #(.D_WIDTH(DW)) bus ();

  fetch_unit #(
    .D_WIDTH  (DW),
    .FQ_DEPTH (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fq_count    (fq_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  bit          m_req;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  ent_t        m_q[$];
  int          wait_cnt;

  // Memory behaviour
  int          lat;
  bit          rand_ack;
  bit          last_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_req    = 1'b0;
    m_stale  = 1'b0;
    m_pc     = 32'h0;
    m_addr   = 32'h0;
    wait_cnt = 0;
  endfunction

  // One clock edge of the fetch unit, seen from the program's point of view.
  function automatic void model_step(input bit ack, input bit rdy, input bit redir,
                                     input logic [31:0] rpc);
    bit   deliver;
    bit   take;
    bit   pending;
    ent_t e;
    deliver = (m_q.size() != 0) && rdy;
    take    = m_req && ack && !m_stale && !redir;
    pending = m_req && !ack;
    if (redir) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (deliver) void'(m_q.pop_front());
      if (take) begin
        e.pc  = m_pc;
        e.ins = mem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (pending) begin
      if (redir) m_stale = 1'b1;
      wait_cnt++;
    end else begin
      m_stale  = 1'b0;
      wait_cnt = 0;
      m_req    = (m_q.size() < DEPTH);
      if (m_req) m_addr = m_pc;
    end
  endfunction

  // Drive one cycle of inputs (starting just after a falling edge), advance
  // the model, and return just after the next falling edge.
  task automatic tick(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit ack;
    ack = m_req && (rand_ack ? ($urandom_range(0, 2) == 0) : (wait_cnt >= lat));
    bus.instr_ready = rdy;
    redirect        = redir;
    redirect_pc     = rpc;
    bus.imem_ack    = ack;
    bus.imem_rdata  = ack ? mem_word(m_addr) : 32'h0;
    model_step(ack, rdy, redir, rpc);
    last_ack = ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    rand_ack        = 1'b0;
    lat             = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    model_reset();
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid); end
    n_tests++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", bus.instr); end
    n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h exp 0", bus.instr_pc); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fq_count); end
    repeat (2) @(negedge clk);
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req got %b exp 0", bus.imem_req); end
    rst = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req got %b exp 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL release_addr got %h exp 0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_addr[%0d] got %h exp %h", i, bus.imem_addr, 32'(i * 4)); end
      n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d] got %b exp 1", i, bus.imem_req); end
      if (i > 0) begin
        n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.instr_valid); end
        n_tests++; if (bus.instr_pc !== 32'((i - 1) * 4)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.instr_pc, 32'((i - 1) * 4)); end
        n_tests++; if (bus.instr !== mem_word(32'((i - 1) * 4))) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, bus.instr, mem_word(32'((i - 1) * 4))); end
        n_tests++; if (fq_count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d exp 1", i, fq_count); end
      end
      tick(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_full();
    int acks;
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (last_ack) acks++;
    end
    n_tests++; if (acks !== 4) begin n_fail++; $display("FAIL full_acks got %0d exp 4", acks); end
    n_tests++; if (fq_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", fq_count); end
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got %b exp 0", bus.imem_req); end
    n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL full_head got %h exp 0", bus.instr_pc); end
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL refill_req got %b exp 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL refill_addr got %h exp 10", bus.imem_addr); end
    n_tests++; if (fq_count !== 3'd3) begin n_fail++; $display("FAIL refill_count got %0d exp 3", fq_count); end
    tick(1'b0, 1'b0, 32'h0);
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL refull_req got %b exp 0", bus.imem_req); end
    n_tests++; if (fq_count !== 3'd4) begin n_fail++; $display("FAIL refull_count got %0d exp 4", fq_count); end
    n_tests++; if (bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL refull_head got %h exp 4", bus.instr_pc); end
  endtask

  task automatic test_drop();
    int guard;
    do_reset();
    lat = 2;
    tick(1'b1, 1'b0, 32'h0);
    guard = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === 32'h8) && guard < 20) begin
      tick(1'b1, 1'b0, 32'h0);
      guard++;
    end
    n_tests++; if (guard >= 20) begin n_fail++; $display("FAIL drop_reach_8 got addr %h exp 8", bus.imem_addr); end
    tick(1'b1, 1'b1, 32'h103);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req got %b exp 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_addr got %h exp 8", bus.imem_addr); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL drop_count got %0d exp 0", fq_count); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid got %b exp 0", bus.instr_valid); end
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_hold_addr got %h exp 8", bus.imem_addr); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL drop_hold_count got %0d exp 0", fq_count); end
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_new_addr got %h exp 100", bus.imem_addr); end
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_new_req got %b exp 1", bus.imem_req); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL drop_discard_count got %0d exp 0", fq_count); end
    guard = 0;
    while (bus.instr_valid !== 1'b1 && guard < 10) begin
      tick(1'b1, 1'b0, 32'h0);
      guard++;
    end
    n_tests++; if (bus.instr_pc !== 32'h100) begin n_fail++; $display("FAIL drop_first_pc got %h exp 100", bus.instr_pc); end
    n_tests++; if (bus.instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL drop_first_instr got %h exp %h", bus.instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL rack_pre_addr got %h exp 4", bus.imem_addr); end
    tick(1'b1, 1'b1, 32'h200);
    n_tests++; if (bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL rack_addr got %h exp 200", bus.imem_addr); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL rack_count got %0d exp 0", fq_count); end
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.instr_pc !== 32'h200) begin n_fail++; $display("FAIL rack_first_pc got %h exp 200", bus.instr_pc); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_tests++; if (bus.instr_valid === 1'b1 && bus.instr_pc === 32'h4) begin n_fail++; $display("FAIL rack_stale_seen got %h exp not 4", bus.instr_pc); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'hFFFF_FFFF);
    n_tests++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align got %h exp fffffffc", bus.imem_addr); end
    tick(1'b1, 1'b0, 32'h0);
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); end
    n_tests++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h exp fffffffc", bus.instr_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req got %b exp 1", bus.imem_req); end
    rst             = 1'b0;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    bus.instr_ready = 1'b0;
    redirect        = 1'b0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req got %b exp 0", bus.imem_req); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", bus.instr_valid); end
    n_tests++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL mid_instr got %h exp 0", bus.instr); end
    n_tests++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL mid_pc got %h exp 0", bus.instr_pc); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", fq_count); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_restart_req got %b exp 1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart_addr got %h exp 0", bus.imem_addr); end
    n_tests++; if (fq_count !== 3'd0) begin n_fail++; $display("FAIL mid_late_ack_count got %0d exp 0", fq_count); end
    bus.imem_rdata = mem_word(32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n_tests++; if (bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_pc got %h/%b exp 0/1", bus.instr_pc, bus.instr_valid); end
    n_tests++; if (bus.instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL mid_first_instr got %h exp %h", bus.instr, mem_word(32'h0)); end
    n_tests++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL mid_next_addr got %h exp 4", bus.imem_addr); end
  endtask

  task automatic test_random();
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    ent_t        h;
    do_reset();
    rand_ack = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      h = (m_q.size() != 0) ? m_q[0] : '0;
      n_tests++; if (bus.imem_req !== m_req) begin n_fail++; $display("FAIL rnd_req@%0d got %b exp %b", c, bus.imem_req, m_req); end
      if (m_req) begin
        n_tests++; if (bus.imem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr@%0d got %h exp %h", c, bus.imem_addr, m_addr); end
      end
      n_tests++; if (bus.instr_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got %b exp %b", c, bus.instr_valid, m_q.size() != 0); end
      n_tests++; if (bus.instr_pc !== h.pc) begin n_fail++; $display("FAIL rnd_pc@%0d got %h exp %h", c, bus.instr_pc, h.pc); end
      n_tests++; if (bus.instr !== h.ins) begin n_fail++; $display("FAIL rnd_instr@%0d got %h exp %h", c, bus.instr, h.ins); end
      n_tests++; if (fq_count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d got %0d exp %0d", c, fq_count, m_q.size()); end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      tick(rdy, redir, rpc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter D_WIDTH SHALL default to 32: width of PC, address and instruction.
REQ-002 Parameter FQ_DEPTH SHALL default to 4: fetch-queue entries, power of two, at least 2.
REQ-003 Parameter RESET_PC SHALL default to 32'h0000_0000: first fetch address.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  D_WIDTH  fetch address; SHALL stay stable while imem_req is high and no ack has arrived.
REQ-008 imem_ack  in  1  memory response valid; sampled only while imem_req is high.
REQ-009 imem_rdata  in  D_WIDTH  instruction word, valid with imem_ack.
REQ-010 redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  D_WIDTH  new fetch address.
REQ-012 instr_valid  out  1  queue head valid toward decode.
REQ-013 instr_ready  in  1  decode accepts head.
REQ-014 instr  out  D_WIDTH  head instruction.
REQ-015 instr_pc  out  D_WIDTH  PC of the head instruction.
REQ-016 fq_count  out  $clog2(FQ_DEPTH+1)  current queue occupancy.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE (no request), REQ (request outstanding), DROP (stale request outstanding, data to be discarded).
REQ-018 imem_req SHALL be a registered output, high exactly in REQ and DROP.
REQ-019 imem_addr SHALL equal fetch_pc in REQ and the stale address in DROP.
REQ-020 At most one request SHALL be outstanding at any time.
REQ-021 Zero-wait memory: an ack in the first cycle of imem_req SHALL complete the request.
REQ-022 IDLE to REQ: SHALL occur when fq_count_next < FQ_DEPTH.
REQ-023 REQ with ack and no redirect:
- imem_rdata and fetch_pc SHALL be enqueued;
- fetch_pc SHALL advance by 4, modulo 2^D_WIDTH, wrapping to 0 after all-ones minus 3;
- next state SHALL be REQ if fq_count_next < FQ_DEPTH, else IDLE.
REQ-024 Dequeue SHALL occur when instr_valid && instr_ready; the same-cycle enqueue and dequeue SHALL leave fq_count unchanged.
REQ-025 instr_valid SHALL equal (fq_count != 0).
REQ-026 instr and instr_pc SHALL be driven to 0 when instr_valid is low.
REQ-027 A request SHALL never be issued without queue space, so the queue SHALL never overflow.
REQ-028 Redirect SHALL have priority over both enqueue and dequeue:
- queue flushed, so fq_count is 0 next cycle;
- fetch_pc set to redirect_pc with bits [1:0] forced to 0.
REQ-029 Redirect in REQ without same-cycle ack SHALL enter DROP; DROP holds the old address until ack, discards the data, then enters REQ at the new fetch_pc.
REQ-030 Redirect in REQ with a same-cycle ack SHALL discard that data and enter REQ at the new fetch_pc.
REQ-031 Redirect in IDLE SHALL enter REQ.
REQ-032 Redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-033 Steady-state throughput with a zero-wait memory and instr_ready held high SHALL be one instruction per cycle.
REQ-034 Latency: ack at edge N SHALL produce instr_valid after edge N.

Reset
REQ-035 While rst is low:
- state = IDLE, fetch_pc = RESET_PC;
- queue empty, fq_count = 0;
- imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-036 The first edge after rst deasserts SHALL move IDLE to REQ, with imem_addr = RESET_PC.
REQ-037 Reset asserted mid-request SHALL abandon the request; a late ack SHALL be ignored because imem_req is low.

Structure
REQ-038 Package fetch_pkg SHALL hold:
- the FSM state enum;
- the PC increment constant (4);
- the RESET_PC default.
REQ-039 Sub-module fetch_queue SHALL implement the circular buffer:
- parameters D_WIDTH and FQ_DEPTH;
- each entry holds {pc, instr};
- read/write pointers wrap modulo FQ_DEPTH;
- synchronous flush input.
fetch_unit SHALL hold the FSM and fetch_pc.

Verification
REQ-040 Reset release, zero-wait memory, ready=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_pc follows one cycle behind.
REQ-041 ready=0, FQ_DEPTH=4 -> exactly 4 acks, then fq_count=4, imem_req=0; ready=1 for one cycle -> one new request at 0x10.
REQ-042 Memory latency 2, redirect to 0x103 while a request to 0x8 is pending -> DROP holds 0x8, its data is discarded, next request is 0x100, queue empty in the meantime.
REQ-043 Redirect coinciding with ack of 0x4 -> 0x4 never appears at instr_pc; next imem_addr = redirect_pc.
REQ-044 fetch_pc = 0xFFFF_FFFC with ack -> next imem_addr = 0x0000_0000.
REQ-045 rst low while imem_req=1 -> outputs at reset values immediately; after release, fetch restarts at RESET_PC.
